// File: rtl/bypass_pkg.sv
// Shared constants for the bypass scoreboard: default widths, the x0 address and stage indices.
package bypass_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned AW      = 5;
  localparam int unsigned X0_ADDR = 0;

  // Producer stage indices; lower index is younger.
  localparam int unsigned EXE   = 0;
  localparam int unsigned MUL1  = 1;
  localparam int unsigned MUL2  = 2;
  localparam int unsigned MUL3  = 3;
  localparam int unsigned MUL4  = 4;
  localparam int unsigned MUL5  = 5;
  localparam int unsigned TL    = 6;
  localparam int unsigned CACHE = 7;

endpackage

// File: rtl/byp_port_sel.sv
// Per-read-port producer search: youngest matching stage wins, then writeback,
// then the pending scoreboard catches writers that are off the stage array.
module byp_port_sel #(
  parameter int unsigned XLEN    = bypass_pkg::XLEN,
  parameter int unsigned AW      = bypass_pkg::AW,
  parameter int unsigned NUM_STG = 8
) (
  input  logic                    i_src_vld,
  input  logic [AW-1:0]           i_src_addr,
  input  logic [NUM_STG-1:0]      i_stg_wr_en,
  input  logic [NUM_STG*AW-1:0]   i_stg_addr,
  input  logic [NUM_STG-1:0]      i_stg_ready,
  input  logic [NUM_STG*XLEN-1:0] i_stg_data,
  input  logic                    i_wb_en,
  input  logic [AW-1:0]           i_wb_addr,
  input  logic [XLEN-1:0]         i_wb_data,
  input  logic                    i_pend_hit,
  output logic                    o_byp_en,
  output logic [XLEN-1:0]         o_byp_data,
  output logic                    o_raw_stall
);
  import bypass_pkg::*;

  logic w_stg_hit;

  always_comb begin
    o_byp_en    = 1'b0;
    o_byp_data  = '0;
    o_raw_stall = 1'b0;
    w_stg_hit   = 1'b0;
    if (i_src_vld && i_src_addr != AW'(X0_ADDR)) begin
      for (int s = 0; s < NUM_STG; s++) begin
        if (!w_stg_hit && i_stg_wr_en[s] && i_stg_addr[s*AW +: AW] == i_src_addr) begin
          w_stg_hit = 1'b1;
          if (i_stg_ready[s]) begin
            o_byp_en   = 1'b1;
            o_byp_data = i_stg_data[s*XLEN +: XLEN];
          end else begin
            o_raw_stall = 1'b1;
          end
        end
      end
      if (!w_stg_hit) begin
        if (i_wb_en && i_wb_addr == i_src_addr) begin
          o_byp_en   = 1'b1;
          o_byp_data = i_wb_data;
        end else if (i_pend_hit) begin
          // Writer in flight but parked off the stage array (e.g. a cache miss).
          o_raw_stall = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bypass_scoreboard.sv
// Decode-side bypass/stall controller with a per-register pending-write scoreboard
// and a saturating stall-cycle counter.
module bypass_scoreboard #(
  parameter int unsigned XLEN    = bypass_pkg::XLEN,
  parameter int unsigned AW      = bypass_pkg::AW,
  parameter int unsigned NUM_RD  = 2,
  parameter int unsigned NUM_STG = 8,
  parameter int unsigned CW      = $clog2(NUM_STG + 2)
) (
  input  logic                    clk_i,
  input  logic                    rsn_i,
  input  logic                    dec_valid_i,
  input  logic [NUM_RD*AW-1:0]    dec_rd_addr_i,
  input  logic [NUM_RD-1:0]       dec_rd_en_i,
  input  logic                    dec_wr_en_i,
  input  logic [AW-1:0]           dec_wr_addr_i,
  input  logic [NUM_STG-1:0]      stg_wr_en_i,
  input  logic [NUM_STG*AW-1:0]   stg_addr_i,
  input  logic [NUM_STG-1:0]      stg_ready_i,
  input  logic [NUM_STG*XLEN-1:0] stg_data_i,
  input  logic                    wb_en_i,
  input  logic [AW-1:0]           wb_addr_i,
  input  logic [XLEN-1:0]         wb_data_i,
  input  logic                    flush_i,
  output logic [NUM_RD-1:0]       byp_en_o,
  output logic [NUM_RD*XLEN-1:0]  byp_data_o,
  output logic                    stall_o,
  output logic [31:0]             stall_cnt_o
);
  import bypass_pkg::*;

  localparam int unsigned NREG = 1 << AW;

  logic [CW-1:0]          r_pend [NREG];
  logic [CW-1:0]          w_pend_d [NREG];
  logic [31:0]            r_stall_cnt;
  logic [NUM_RD-1:0]      w_byp_en;
  logic [NUM_RD-1:0]      w_raw_stall;
  logic [NUM_RD-1:0]      w_pend_hit;
  logic [NUM_RD*XLEN-1:0] w_byp_data;
  logic                   w_waw_stall;
  logic                   w_stall;
  logic                   w_issue;
  logic                   w_retire;

  // Pending count net of a same-cycle retire to the same register.
  always_comb begin
    for (int r = 0; r < NUM_RD; r++) begin
      w_pend_hit[r] = r_pend[dec_rd_addr_i[r*AW +: AW]] >
                      CW'(wb_en_i && wb_addr_i == dec_rd_addr_i[r*AW +: AW]);
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_port
    byp_port_sel #(
      .XLEN    (XLEN),
      .AW      (AW),
      .NUM_STG (NUM_STG)
    ) u_sel (
      .i_src_vld   (dec_valid_i & dec_rd_en_i[g]),
      .i_src_addr  (dec_rd_addr_i[g*AW +: AW]),
      .i_stg_wr_en (stg_wr_en_i),
      .i_stg_addr  (stg_addr_i),
      .i_stg_ready (stg_ready_i),
      .i_stg_data  (stg_data_i),
      .i_wb_en     (wb_en_i),
      .i_wb_addr   (wb_addr_i),
      .i_wb_data   (wb_data_i),
      .i_pend_hit  (w_pend_hit[g]),
      .o_byp_en    (w_byp_en[g]),
      .o_byp_data  (w_byp_data[g*XLEN +: XLEN]),
      .o_raw_stall (w_raw_stall[g])
    );
  end

  always_comb begin
    w_waw_stall = 1'b0;
    if (dec_valid_i && dec_wr_en_i && dec_wr_addr_i != AW'(X0_ADDR)) begin
      for (int s = 0; s < NUM_STG; s++) begin
        if (stg_wr_en_i[s] && stg_addr_i[s*AW +: AW] == dec_wr_addr_i && !stg_ready_i[s]) begin
          w_waw_stall = 1'b1;
        end
      end
    end
  end

  assign w_stall  = (|w_raw_stall) | w_waw_stall;
  assign w_issue  = dec_valid_i & dec_wr_en_i & (dec_wr_addr_i != AW'(X0_ADDR)) &
                    ~w_stall & ~flush_i;
  assign w_retire = wb_en_i & (wb_addr_i != AW'(X0_ADDR));

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      w_pend_d[i] = r_pend[i];
      if (flush_i) begin
        w_pend_d[i] = '0;
      end else if (w_issue && dec_wr_addr_i == AW'(i) &&
                   !(w_retire && wb_addr_i == AW'(i))) begin
        if (r_pend[i] != '1) w_pend_d[i] = r_pend[i] + CW'(1);
      end else if (w_retire && wb_addr_i == AW'(i) &&
                   !(w_issue && dec_wr_addr_i == AW'(i))) begin
        if (r_pend[i] != '0) w_pend_d[i] = r_pend[i] - CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      for (int i = 0; i < NREG; i++) r_pend[i] <= '0;
      r_stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) r_pend[i] <= w_pend_d[i];
      if (w_stall && !flush_i && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign byp_en_o    = rsn_i ? w_byp_en : '0;
  assign byp_data_o  = rsn_i ? w_byp_data : '0;
  assign stall_o     = rsn_i & w_stall;
  assign stall_cnt_o = r_stall_cnt;

  a_retire_at_zero: assert property (@(posedge clk_i) disable iff (!rsn_i)
    (w_retire && !flush_i && !(w_issue && dec_wr_addr_i == wb_addr_i)) |->
      r_pend[wb_addr_i] != '0);

  a_issue_at_max: assert property (@(posedge clk_i) disable iff (!rsn_i)
    (w_issue && !(w_retire && wb_addr_i == dec_wr_addr_i)) |->
      r_pend[dec_wr_addr_i] != '1);

endmodule

// File: tb/tb_bypass_scoreboard.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_bypass_scoreboard;
  localparam int XLEN = 32;
  localparam int AW = 5;
  localparam int NUM_RD = 2;
  localparam int NUM_STG = 8;
  localparam int PMAX = 15;

  logic clk = 1'b0;
  logic rsn = 1'b0;
  always #5 clk = ~clk;

  // Stimulus in array form
  logic            dec_valid;
  logic [AW-1:0]   rd_addr [NUM_RD];
  logic [NUM_RD-1:0] rd_en;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [NUM_STG-1:0] s_en, s_rdy;
  logic [AW-1:0]   s_addr [NUM_STG];
  logic [XLEN-1:0] s_data [NUM_STG];
  logic            wb_en;
  logic [AW-1:0]   wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            flush;

  logic [NUM_RD*AW-1:0]    rd_addr_bus;
  logic [NUM_STG*AW-1:0]   s_addr_bus;
  logic [NUM_STG*XLEN-1:0] s_data_bus;
  logic [NUM_RD-1:0]       byp_en;
  logic [NUM_RD*XLEN-1:0]  byp_data;
  logic                    stall;
  logic [31:0]             stall_cnt;

  always_comb begin
    for (int r = 0; r < NUM_RD; r++) rd_addr_bus[r*AW +: AW] = rd_addr[r];
  end
  always_comb begin
    for (int s = 0; s < NUM_STG; s++) begin
      s_addr_bus[s*AW +: AW]     = s_addr[s];
      s_data_bus[s*XLEN +: XLEN] = s_data[s];
    end
  end

  bypass_scoreboard #(
    .XLEN    (XLEN),
    .AW      (AW),
    .NUM_RD  (NUM_RD),
    .NUM_STG (NUM_STG)
  ) u_dut (
    .clk_i         (clk),
    .rsn_i         (rsn),
    .dec_valid_i   (dec_valid),
    .dec_rd_addr_i (rd_addr_bus),
    .dec_rd_en_i   (rd_en),
    .dec_wr_en_i   (wr_en),
    .dec_wr_addr_i (wr_addr),
    .stg_wr_en_i   (s_en),
    .stg_addr_i    (s_addr_bus),
    .stg_ready_i   (s_rdy),
    .stg_data_i    (s_data_bus),
    .wb_en_i       (wb_en),
    .wb_addr_i     (wb_addr),
    .wb_data_i     (wb_data),
    .flush_i       (flush),
    .byp_en_o      (byp_en),
    .byp_data_o    (byp_data),
    .stall_o       (stall),
    .stall_cnt_o   (stall_cnt)
  );

  // Reference model state
  int          pend [32];
  logic [31:0] m_cnt;
  logic [NUM_RD-1:0] exp_en;
  logic [NUM_RD*XLEN-1:0] exp_data;
  logic        exp_stall;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_eval();
    int hit;
    exp_stall = 1'b0;
    exp_en    = '0;
    exp_data  = '0;
    if (rsn) begin
      for (int r = 0; r < NUM_RD; r++) begin
        if (dec_valid && rd_en[r] && rd_addr[r] != 0) begin
          hit = -1;
          for (int s = NUM_STG - 1; s >= 0; s--)
            if (s_en[s] && s_addr[s] == rd_addr[r]) hit = s;
          if (hit >= 0) begin
            if (s_rdy[hit]) begin
              exp_en[r] = 1'b1;
              exp_data[r*XLEN +: XLEN] = s_data[hit];
            end else exp_stall = 1'b1;
          end else if (wb_en && wb_addr == rd_addr[r]) begin
            exp_en[r] = 1'b1;
            exp_data[r*XLEN +: XLEN] = wb_data;
          end else if (pend[rd_addr[r]] > 0) begin
            exp_stall = 1'b1;
          end
        end
      end
      if (dec_valid && wr_en && wr_addr != 0)
        for (int s = 0; s < NUM_STG; s++)
          if (s_en[s] && s_addr[s] == wr_addr && !s_rdy[s]) exp_stall = 1'b1;
    end
  endtask

  task automatic model_clock();
    bit iss, ret;
    if (!rsn) begin
      for (int i = 0; i < 32; i++) pend[i] = 0;
      m_cnt = '0;
    end else if (flush) begin
      for (int i = 0; i < 32; i++) pend[i] = 0;
    end else begin
      iss = dec_valid && wr_en && wr_addr != 0 && !exp_stall;
      ret = wb_en && wb_addr != 0;
      if (!(iss && ret && wr_addr == wb_addr)) begin
        if (iss && pend[wr_addr] < PMAX) pend[wr_addr]++;
        if (ret && pend[wb_addr] > 0) pend[wb_addr]--;
      end
      if (exp_stall && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end
  endtask

  task automatic settle(input string tag);
    #1;
    model_eval();
    check({tag, ".stall"}, 64'(stall), 64'(exp_stall));
    check({tag, ".cnt"}, 64'(stall_cnt), 64'(m_cnt));
    check({tag, ".en"}, 64'(byp_en), 64'(exp_en));
    check({tag, ".data"}, 64'(byp_data), 64'(exp_data));
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic step(input string tag);
    settle(tag);
    tick();
  endtask

  task automatic idle();
    dec_valid = 0; rd_en = '0; wr_en = 0; wr_addr = '0;
    s_en = '0; s_rdy = '0; wb_en = 0; wb_addr = '0; wb_data = '0; flush = 0;
    for (int r = 0; r < NUM_RD; r++) rd_addr[r] = '0;
    for (int s = 0; s < NUM_STG; s++) begin s_addr[s] = '0; s_data[s] = '0; end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) pend[i] = 0;
    m_cnt = '0;
    idle();
    // Reset must force outputs even with a forwardable operand present
    s_en[0] = 1; s_addr[0] = 5; s_rdy[0] = 1; s_data[0] = 32'h1234;
    dec_valid = 1; rd_en = 2'b01; rd_addr[0] = 5;
    @(negedge clk);
    step("reset");
    rsn = 1'b1;

    // Youngest stage ready forward
    settle("fwd_exe");
    check("fwd_exe.val", 64'(byp_data[31:0]), 64'h1234);
    check("fwd_exe.en0", 64'(byp_en[0]), 64'd1);
    tick();

    // Unready MUL1 shadows ready TL on x7
    idle();
    s_en[1] = 1; s_addr[1] = 7; s_rdy[1] = 0;
    s_en[6] = 1; s_addr[6] = 7; s_rdy[6] = 1; s_data[6] = 32'hAA;
    dec_valid = 1; rd_en = 2'b10; rd_addr[1] = 7;
    for (int i = 0; i < 3; i++) step("youngest");
    settle("youngest_cnt");
    check("youngest.stall", 64'(stall), 64'd1);
    check("youngest.cnt3", 64'(stall_cnt), 64'd3);
    tick();

    // x0 never forwards or stalls
    idle();
    s_en[0] = 1; s_addr[0] = 0; s_rdy[0] = 1; s_data[0] = 32'h55;
    dec_valid = 1; rd_en = 2'b11; wr_en = 1; wr_addr = 0;
    settle("x0");
    check("x0.en", 64'(byp_en), 64'd0);
    tick();

    // Parked x9 writer
    idle();
    dec_valid = 1; wr_en = 1; wr_addr = 9;
    step("x9_issue");
    idle();
    for (int i = 0; i < 3; i++) step("x9_park");
    dec_valid = 1; rd_en = 2'b01; rd_addr[0] = 9;
    settle("x9_hidden");
    check("x9_hidden.stall", 64'(stall), 64'd1);
    tick();
    wb_en = 1; wb_addr = 9; wb_data = 32'hCAFE;
    settle("x9_wb");
    check("x9_wb.data", 64'(byp_data[31:0]), 64'hCAFE);
    check("x9_wb.stall", 64'(stall), 64'd0);
    tick();
    wb_en = 0;
    settle("x9_done");
    check("x9_done.stall", 64'(stall), 64'd0);
    tick();

    // Same-cycle issue and retire on x3, then flush
    idle();
    dec_valid = 1; wr_en = 1; wr_addr = 3;
    step("x3_issue");
    wb_en = 1; wb_addr = 3; wb_data = 32'h3;
    step("x3_both");
    idle();
    dec_valid = 1; rd_en = 2'b01; rd_addr[0] = 3;
    settle("x3_held");
    check("x3_held.stall", 64'(stall), 64'd1);
    tick();
    idle();
    flush = 1;
    step("flush");
    idle();
    dec_valid = 1; rd_en = 2'b01; rd_addr[0] = 3;
    settle("x3_flushed");
    check("x3_flushed.stall", 64'(stall), 64'd0);
    tick();

    // WAW stall then asynchronous reset mid-stall
    idle();
    s_en[2] = 1; s_addr[2] = 4; s_rdy[2] = 0;
    s_en[0] = 1; s_addr[0] = 6; s_rdy[0] = 1; s_data[0] = 32'h66;
    dec_valid = 1; wr_en = 1; wr_addr = 4; rd_en = 2'b01; rd_addr[0] = 6;
    step("waw");
    settle("waw2");
    check("waw.stall", 64'(stall), 64'd1);
    rsn = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) pend[i] = 0;
    m_cnt = '0;
    check("rst_mid.en", 64'(byp_en), 64'd0);
    check("rst_mid.stall", 64'(stall), 64'd0);
    check("rst_mid.cnt", 64'(stall_cnt), 64'd0);
    tick();
    rsn = 1'b1;
    idle();
    step("post_rst");

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      int a;
      idle();
      dec_valid = ($urandom_range(0, 3) != 0);
      rd_en = 2'($urandom);
      for (int r = 0; r < NUM_RD; r++) rd_addr[r] = AW'($urandom_range(0, 7));
      wr_en = $urandom_range(0, 1) == 1;
      wr_addr = AW'($urandom_range(0, 7));
      if (pend[wr_addr] >= PMAX - 2) wr_en = 0;
      for (int s = 0; s < NUM_STG; s++) begin
        s_en[s] = ($urandom_range(0, 2) == 0);
        s_addr[s] = AW'($urandom_range(0, 7));
        s_rdy[s] = ($urandom_range(0, 2) != 0);
        s_data[s] = $urandom;
      end
      a = $urandom_range(0, 7);
      if ((a == 0 || pend[a] > 0) && $urandom_range(0, 1) == 1) begin
        wb_en = 1; wb_addr = AW'(a); wb_data = $urandom;
      end
      flush = ($urandom_range(0, 24) == 0);
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
